hd44780_bus_writer: RTL and testbench

//  Consumes the 1-cycle tick strobe from the timebase counter. Turns one accepted byte
//  (instruction or data) into a correctly timed HD44780 write cycle on RS/RW/E/DB.

---
 rtl/hd44780_bus_writer_pkg.sv | 31 +++
 rtl/hd44780_bus_writer.sv | 134 +++++++++++++
 tb/tb_hd44780_bus_writer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/hd44780_bus_writer_pkg.sv
// Shared definitions for the HD44780 bus writer: FSM states, default timings, command codes.
package hd44780_bus_writer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        E_HIGH = 3'd2,
        HOLD   = 3'd3,
        EXEC   = 3'd4
    } state_t;

    localparam int DEF_T_AS        = 2;
    localparam int DEF_T_PW        = 2;
    localparam int DEF_T_H         = 2;
    localparam int DEF_T_EXEC      = 40;
    localparam int DEF_T_EXEC_LONG = 1600;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    function automatic int max5(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/hd44780_bus_writer.sv
// Turns one accepted instruction/data byte into a timed HD44780 write cycle,
// then holds off for the command execution time. Timing is counted in timebase ticks.
module hd44780_bus_writer
    import hd44780_bus_writer_pkg::*;
#(
    parameter int FOUR_BIT    = 0,
    parameter int T_AS        = DEF_T_AS,
    parameter int T_PW        = DEF_T_PW,
    parameter int T_H         = DEF_T_H,
    parameter int T_EXEC      = DEF_T_EXEC,
    parameter int T_EXEC_LONG = DEF_T_EXEC_LONG,
    localparam int DBW        = (FOUR_BIT != 0) ? 4 : 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic           in_valid,
    input  logic           in_rs,
    input  logic [7:0]     in_data,
    output logic           in_ready,
    output logic           busy,
    output logic           lcd_rs,
    output logic           lcd_rw,
    output logic           lcd_e,
    output logic [DBW-1:0] lcd_db
);

    localparam int TMAX = max5(T_EXEC_LONG, T_EXEC, T_AS, T_PW, T_H);
    localparam int CW   = $clog2(TMAX + 1);

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n, last;
    logic           nib, nib_n;
    logic           rs_q, rs_n;
    logic [7:0]     data_q, data_n;
    logic           e_n, rdy_n, busy_n, lrs_n;
    logic [DBW-1:0] db_n;
    logic [7:0]     hi_sel, lo_sel;
    logic           done, long_exec;

    // clear (0x01) and home (0x02/0x03) need the long execution wait
    assign long_exec = !rs_q && (data_q == CMD_CLEAR || data_q[7:1] == CMD_HOME[7:1]);

    assign hi_sel = (FOUR_BIT != 0) ? {4'b0, in_data[7:4]} : in_data;
    assign lo_sel = {4'b0, data_q[3:0]};
    assign lcd_rw = 1'b0;

    always_comb begin
        last = '0;
        case (state)
            SETUP:   last = CW'(T_AS - 1);
            E_HIGH:  last = CW'(T_PW - 1);
            HOLD:    last = CW'(T_H - 1);
            EXEC:    last = long_exec ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
            default: last = '0;
        endcase
    end

    assign done = tick && (cnt == last);

    always_comb begin
        state_n = state;
        cnt_n   = tick ? cnt + CW'(1) : cnt;
        nib_n   = nib;
        rs_n    = rs_q;
        data_n  = data_q;
        lrs_n   = lcd_rs;
        db_n    = lcd_db;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (in_valid && in_ready) begin
                    state_n = SETUP;
                    nib_n   = 1'b0;
                    rs_n    = in_rs;
                    data_n  = in_data;
                    lrs_n   = in_rs;
                    db_n    = hi_sel[DBW-1:0];
                end
            end
            SETUP:  if (done) state_n = E_HIGH;
            E_HIGH: if (done) state_n = HOLD;
            HOLD: begin
                if (done) begin
                    if (FOUR_BIT != 0 && !nib) begin
                        state_n = SETUP;
                        nib_n   = 1'b1;
                        db_n    = lo_sel[DBW-1:0];
                    end else begin
                        state_n = EXEC;
                    end
                end
            end
            EXEC:    if (done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // every state entry restarts the tick count
        if (state_n != state) cnt_n = '0;
        e_n    = (state_n == E_HIGH);
        rdy_n  = (state_n == IDLE);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            nib      <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_db   <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            nib      <= nib_n;
            rs_q     <= rs_n;
            data_q   <= data_n;
            in_ready <= rdy_n;
            busy     <= busy_n;
            lcd_rs   <= lrs_n;
            lcd_e    <= e_n;
            lcd_db   <= db_n;
        end
    end

    always_ff @(posedge clk) begin
        assert (T_AS > 0 && T_PW > 0 && T_H > 0 && T_EXEC > 0 && T_EXEC_LONG > 0);
    end

endmodule

// File: tb/tb_hd44780_bus_writer.sv
// Directed bench for hd44780_bus_writer: 8-bit and 4-bit instances, tick every 6 clk.
module tb_hd44780_bus_writer;

    logic       clk = 0, rst = 0, tick = 0;
    int         phase = 0;
    logic       v8 = 0, v4 = 0, in_rs = 0;
    logic [7:0] in_data = 0;

    logic       rdy8, busy8, rs8, rw8, e8;
    logic [7:0] db8;
    logic       rdy4, busy4, rs4, rw4, e4;
    logic [3:0] db4;

    int vectors = 0, miss = 0;

    hd44780_bus_writer dut8 (
        .clk(clk), .rst(rst), .tick(tick), .in_valid(v8), .in_rs(in_rs), .in_data(in_data),
        .in_ready(rdy8), .busy(busy8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_e(e8), .lcd_db(db8));

    hd44780_bus_writer #(.FOUR_BIT(1)) dut4 (
        .clk(clk), .rst(rst), .tick(tick), .in_valid(v4), .in_rs(in_rs), .in_data(in_data),
        .in_ready(rdy4), .busy(busy4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_e(e4), .lcd_db(db4));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        phase = (phase + 1) % 6;
        tick  = (phase == 5);
    end

    // tick-counting monitors; counters restart on every accept
    int   acc8 = 0, bt8 = 0, bc8 = 0, et8 = 0, ec8 = 0, rise8 = 0;
    int   acc4 = 0, bt4 = 0, ec4 = 0, rise4 = 0;
    logic e8_prev = 0, e4_prev = 0;
    logic [7:0] log8db [0:63];
    logic       log8rs [0:63];
    logic [3:0] log4db [0:63];

    always @(posedge clk) begin
        e8_prev <= e8;
        if (v8 && rdy8) begin
            acc8 <= acc8 + 1; bt8 <= 0; bc8 <= 0; et8 <= 0; ec8 <= 0;
        end else begin
            if (busy8) begin
                bc8 <= bc8 + 1;
                if (tick) bt8 <= bt8 + 1;
            end
            if (e8) begin
                ec8 <= ec8 + 1;
                if (tick) et8 <= et8 + 1;
            end
        end
        if (e8 && !e8_prev) begin
            log8db[rise8 & 63] <= db8;
            log8rs[rise8 & 63] <= rs8;
            rise8 <= rise8 + 1;
        end
    end

    always @(posedge clk) begin
        e4_prev <= e4;
        if (v4 && rdy4) begin
            acc4 <= acc4 + 1; bt4 <= 0; ec4 <= 0;
        end else begin
            if (busy4 && tick) bt4 <= bt4 + 1;
            if (e4) ec4 <= ec4 + 1;
        end
        if (e4 && !e4_prev) begin
            log4db[rise4 & 63] <= db4;
            rise4 <= rise4 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready8(input string tag, input int max);
        int n = 0;
        while (rdy8 !== 1'b1 && n < max) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, 32'(rdy8), 1);
    endtask

    task automatic wait_ready4(input string tag, input int max);
        int n = 0;
        while (rdy4 !== 1'b1 && n < max) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, 32'(rdy4), 1);
    endtask

    task automatic send8(input logic rs, input logic [7:0] d);
        in_rs = rs; in_data = d; v8 = 1;
        @(negedge clk);
        v8 = 0;
    endtask

    task automatic xfer8(input string tag, input logic rs, input logic [7:0] d, input int exp_ticks);
        int r0;
        wait_ready8({tag, "_pre"}, 20000);
        r0 = rise8;
        send8(rs, d);
        wait_ready8({tag, "_done"}, 12000);
        chk({tag, "_busy_ticks"}, bt8, exp_ticks);
        chk({tag, "_epulses"}, rise8 - r0, 1);
        chk({tag, "_db_at_e"}, log8db[r0 & 63], d);
        chk({tag, "_rs_at_e"}, 32'(log8rs[r0 & 63]), 32'(rs));
    endtask

    initial begin
        int n, a0, r0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", rdy8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_e", e8, 0);
        chk("rst_db", db8, 0);
        chk("rst_rs", rs8, 0);
        chk("rst_rw", rw8, 0);
        chk("rst_ready4", rdy4, 0);
        rst = 1;
        #1 chk("rel_ready_before_edge", rdy8, 0);
        @(negedge clk);
        chk("rel_ready_after_edge", rdy8, 1);
        chk("rel_busy", busy8, 0);

        // single data byte, 8-bit bus
        xfer8("t1", 1'b1, 8'h41, 46);
        chk("t1_e_ticks", et8, 2);
        chk("t1_e_cycles", ec8, 12);
        chk("t1_db_hold_idle", db8, 8'h41);
        chk("t1_busy_idle", busy8, 0);
        chk("t1_rw", rw8, 0);

        // execution-time selection
        xfer8("t2_clear", 1'b0, 8'h01, 1606);
        xfer8("t2_home3", 1'b0, 8'h03, 1606);
        xfer8("t2_entry", 1'b0, 8'h06, 46);
        xfer8("t2_zero", 1'b0, 8'h00, 46);
        xfer8("t2_04", 1'b0, 8'h04, 46);
        xfer8("t2_data01", 1'b1, 8'h01, 46);

        // 4-bit bus: two nibbles, one exec wait
        wait_ready4("t3_pre", 100);
        r0 = rise4;
        in_rs = 1; in_data = 8'hA5; v4 = 1;
        @(negedge clk);
        v4 = 0;
        wait_ready4("t3_done", 2000);
        chk("t3_busy_ticks", bt4, 52);
        chk("t3_epulses", rise4 - r0, 2);
        chk("t3_hi_nib", log4db[r0 & 63], 4'hA);
        chk("t3_lo_nib", log4db[(r0 + 1) & 63], 4'h5);
        chk("t3_e_cycles", ec4, 24);

        // valid held high across three bytes; data changes while busy are ignored
        wait_ready8("t4_pre", 100);
        a0 = acc8; r0 = rise8;
        in_rs = 1; in_data = 8'h11; v8 = 1;
        for (int b = 1; b <= 3; b++) begin
            n = 0;
            while (acc8 - a0 < b && n < 2000) begin @(negedge clk); n++; end
            chk("t4_accept_seen", acc8 - a0, b);
            if (b == 3) v8 = 0;
            in_data = 8'hEE;
            repeat (20) @(negedge clk);
            in_data = (b == 1) ? 8'h22 : 8'h33;
        end
        wait_ready8("t4_done", 2000);
        chk("t4_accepts", acc8 - a0, 3);
        chk("t4_epulses", rise8 - r0, 3);
        chk("t4_db0", log8db[r0 & 63], 8'h11);
        chk("t4_db1", log8db[(r0 + 1) & 63], 8'h22);
        chk("t4_db2", log8db[(r0 + 2) & 63], 8'h33);

        // reset asserted while E is high
        wait_ready8("t5_pre", 100);
        send8(1'b1, 8'h77);
        n = 0;
        while (e8 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("t5_e_seen", e8, 1);
        #1 rst = 0;
        #1;
        chk("t5_e_async", e8, 0);
        chk("t5_db", db8, 0);
        chk("t5_rs", rs8, 0);
        chk("t5_busy", busy8, 0);
        chk("t5_ready", rdy8, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("t5_ready_after", rdy8, 1);
        xfer8("t5_new", 1'b1, 8'h5A, 46);

        // tick on the accept edge vs one cycle after it
        wait_ready8("t6a_pre", 100);
        n = 0;
        while (phase != 5 && n < 10) begin @(negedge clk); n++; end
        send8(1'b1, 8'h30);
        wait_ready8("t6a_done", 2000);
        chk("t6a_busy_ticks", bt8, 46);
        chk("t6a_busy_cycles", bc8, 276);
        chk("t6a_e_ticks", et8, 2);

        n = 0;
        while (phase != 4 && n < 10) begin @(negedge clk); n++; end
        send8(1'b1, 8'h31);
        wait_ready8("t6b_done", 2000);
        chk("t6b_busy_ticks", bt8, 46);
        chk("t6b_busy_cycles", bc8, 271);
        chk("t6b_e_cycles", ec8, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
